// File: rtl/d_ff_pkg.sv
// d_ff_pkg: shared width default and clear-value helper for the d_ff_sync_clear family.
package d_ff_pkg;
  localparam int DEFAULT_WIDTH = 1;
  localparam int MAX_WIDTH = 4096;
  function automatic logic [MAX_WIDTH-1:0] all_zeros();
    return '0;
  endfunction
endpackage

// File: rtl/d_ff_stage.sv
// d_ff_stage: single WIDTH-bit register with synchronous active-high clear.
// Optional hold-enable port i_en when D_FF_SYNC_CLEAR_ENABLE_EN is defined.
module d_ff_stage import d_ff_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = WIDTH'(all_zeros())
) (
  input  logic             i_clk,
  input  logic             i_clear,
`ifdef D_FF_SYNC_CLEAR_ENABLE_EN
  input  logic             i_en,
`endif
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q
);
`ifdef D_FF_SYNC_CLEAR_ENABLE_EN
  always_ff @(posedge i_clk)
    if (i_clear) o_q <= CLEAR_VALUE;
    else if (i_en) o_q <= i_data;
`else
  always_ff @(posedge i_clk)
    o_q <= i_clear ? CLEAR_VALUE : i_data;
`endif
endmodule

// File: rtl/d_ff_sync_clear.sv
// d_ff_sync_clear: STAGES-deep chain of WIDTH-bit registers with synchronous clear.
// Optional enable (i_en) when D_FF_SYNC_CLEAR_ENABLE_EN is defined.
module d_ff_sync_clear import d_ff_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STAGES = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = WIDTH'(all_zeros())
) (
  input  logic             i_clk,
  input  logic             i_clear,
`ifdef D_FF_SYNC_CLEAR_ENABLE_EN
  input  logic             i_en,
`endif
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] chain [STAGES+1];
  assign chain[0] = i_data;
  assign o_q = chain[STAGES];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    d_ff_stage #(.WIDTH(WIDTH), .CLEAR_VALUE(CLEAR_VALUE)) u_stage (
      .i_clk   (i_clk),
      .i_clear (i_clear),
`ifdef D_FF_SYNC_CLEAR_ENABLE_EN
      .i_en    (i_en),
`endif
      .i_data  (chain[s]),
      .o_q     (chain[s+1])
    );
  end
endmodule

// File: tb/tb_d_ff_sync_clear.sv
// tb_d_ff_sync_clear: directed scoreboard bench for a default instance and a WIDTH=8/STAGES=3 instance.
module tb_d_ff_sync_clear;
  typedef struct {
    string tag;
    logic [7:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic a_clear = 1'b1, a_data = 1'b0, a_q;
  logic b_clear = 1'b1;
  logic [7:0] b_data = 8'h00, b_q;
`ifdef D_FF_SYNC_CLEAR_ENABLE_EN
  logic a_en = 1'b1, b_en = 1'b1;
`endif
  exp_t qa[$], qb[$];
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  d_ff_sync_clear u_a (
    .i_clk   (clk),
    .i_clear (a_clear),
`ifdef D_FF_SYNC_CLEAR_ENABLE_EN
    .i_en    (a_en),
`endif
    .i_data  (a_data),
    .o_q     (a_q)
  );
  d_ff_sync_clear #(.WIDTH(8), .STAGES(3), .CLEAR_VALUE(8'hA5)) u_b (
    .i_clk   (clk),
    .i_clear (b_clear),
`ifdef D_FF_SYNC_CLEAR_ENABLE_EN
    .i_en    (b_en),
`endif
    .i_data  (b_data),
    .o_q     (b_q)
  );
  task automatic check_all();
    exp_t e;
    while (qa.size() > 0) begin
      e = qa.pop_front();
      checks++;
      assert (a_q === e.v[0]) else begin
        fails++;
        $error("FAIL %s: o_q=%b expected %b", e.tag, a_q, e.v[0]);
      end
    end
    while (qb.size() > 0) begin
      e = qb.pop_front();
      checks++;
      assert (b_q === e.v) else begin
        fails++;
        $error("FAIL %s: o_q=%h expected %h", e.tag, b_q, e.v);
      end
    end
  endtask
  task automatic edge_check();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic a_step(input logic c, input logic d, input logic e, input logic x, input string tag);
    @(negedge clk);
    a_clear = c;
    a_data = d;
`ifdef D_FF_SYNC_CLEAR_ENABLE_EN
    a_en = e;
`else
    if (e !== 1'b1) $display("enable step skipped in this build");
`endif
    qa.push_back('{tag, {7'd0, x}});
    edge_check();
  endtask
  task automatic b_step(input logic c, input logic [7:0] d, input logic [7:0] x, input string tag);
    @(negedge clk);
    b_clear = c;
    b_data = d;
    qb.push_back('{tag, x});
    edge_check();
  endtask
  initial begin
    a_step(1, 0, 1, 0, "a_reset");
    a_step(0, 1, 1, 1, "a_data1");
    a_step(0, 0, 1, 0, "a_data0");
    a_step(0, 1, 1, 1, "a_reload1");
    a_step(1, 1, 1, 0, "a_clear_prio");
    a_step(0, 1, 1, 1, "a_after_clear");
    @(negedge clk);
    a_data = 1'b1;
    #2 a_clear = 1'b1;
    #1 qa.push_back('{"a_glitch_mid", 8'h01});
    check_all();
    #1 a_clear = 1'b0;
    qa.push_back('{"a_glitch_edge", 8'h01});
    edge_check();
`ifdef D_FF_SYNC_CLEAR_ENABLE_EN
    a_step(0, 0, 0, 1, "a_hold1");
    a_step(0, 0, 0, 1, "a_hold2");
    a_step(0, 0, 0, 1, "a_hold3");
    a_step(1, 0, 0, 0, "a_clear_no_en");
    a_step(0, 1, 1, 1, "a_en_load");
`endif
    b_step(1, 8'h00, 8'hA5, "b_reset");
    b_step(0, 8'h01, 8'hA5, "b_fill1");
    b_step(0, 8'h02, 8'hA5, "b_fill2");
    b_step(0, 8'h03, 8'h01, "b_out01");
    b_step(0, 8'h04, 8'h02, "b_out02");
    b_step(0, 8'h05, 8'h03, "b_out03");
    b_step(1, 8'h06, 8'hA5, "b_mid_clear");
    b_step(0, 8'h07, 8'hA5, "b_flush1");
    b_step(0, 8'h08, 8'hA5, "b_flush2");
    b_step(0, 8'h09, 8'h07, "b_out07");
    b_step(0, 8'h0A, 8'h08, "b_out08");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
